// File: rtl/lvt_pkg.sv
// Shared defaults and helpers for the LVT multiported hash memory front end.
package lvt_pkg;

    localparam int LVT_P           = 4;
    localparam int LVT_DATA_WIDTH  = 32;
    localparam int LVT_INDEX_WIDTH = 8;
    localparam int LVT_PORT_W      = $clog2(LVT_P);

    typedef logic [LVT_PORT_W-1:0] port_idx_t;

    // Position of port k in the round-robin order that starts at ptr; 0 is the highest priority.
    function automatic int prio_rank(input int k, input int ptr, input int p);
        return (k - ptr + p) % p;
    endfunction

endpackage

// File: rtl/lvt_rd_delay_line.sv
// P-wide valid shift register: a read enable entering here reappears RD_LAT cycles later.
module lvt_rd_delay_line #(
    parameter int P      = 4,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [P-1:0] din,
    output logic [P-1:0] dout
);

    logic [RD_LAT:1][P-1:0] vld_pipe;

    // Async clear drops every in-flight read so nothing surfaces after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= din;
            for (int s = 2; s <= RD_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
            end
        end
    end

    assign dout = vld_pipe[RD_LAT];

endmodule

// File: rtl/lvt_port_scheduler.sv
// Round-robin hazard scheduler for the P-port LVT memory: grants non-conflicting requests,
// registers them into the port registers and tracks read latency for rsp_valid.
module lvt_port_scheduler
    import lvt_pkg::*;
#(
    parameter int P           = LVT_P,
    parameter int DATA_WIDTH  = LVT_DATA_WIDTH,
    parameter int INDEX_WIDTH = LVT_INDEX_WIDTH,
    parameter int RD_LAT      = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [P-1:0]             req_valid,
    input  logic [P-1:0]             req_we,
    input  logic [P*INDEX_WIDTH-1:0] req_addr,
    input  logic [P*DATA_WIDTH-1:0]  req_wdata,
    output logic [P-1:0]             req_ready,
    output logic [P-1:0]             mem_wen,
    output logic [P-1:0]             mem_ren,
    output logic [P*INDEX_WIDTH-1:0] mem_addr,
    output logic [P*DATA_WIDTH-1:0]  mem_wdata,
    input  logic [P*DATA_WIDTH-1:0]  mem_rdata,
    output logic [P-1:0]             rsp_valid,
    output logic [P*DATA_WIDTH-1:0]  rsp_data,
    output logic [$clog2(P)-1:0]     rr_ptr,
    output logic [CNT_WIDTH-1:0]     conflict_cnt
);

    localparam int PW = $clog2(P);

    logic [P-1:0][INDEX_WIDTH-1:0] addr_v, addr_q;
    logic [P-1:0][DATA_WIDTH-1:0]  wdata_v, wdata_q;
    logic [P-1:0][P-1:0]           clash;
    logic [P-1:0]                  deny, grant;
    logic                          any_deny;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    // clash[i][j]: j would block i if j ranked higher (same index, at least one write).
    for (genvar i = 0; i < P; i++) begin : g_row
        for (genvar j = 0; j < P; j++) begin : g_col
            if (i == j) begin : g_self
                assign clash[i][j] = 1'b0;
            end else begin : g_pair
                assign clash[i][j] = req_valid[i] & req_valid[j] &
                                     (addr_v[i] == addr_v[j]) & (req_we[i] | req_we[j]);
            end
        end
    end

    // Denial looks at every valid higher-priority request, granted or not.
    always_comb begin
        deny = '0;
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < P; j++) begin
                if (clash[i][j] &&
                    prio_rank(j, int'(rr_ptr), P) < prio_rank(i, int'(rr_ptr), P)) begin
                    deny[i] = 1'b1;
                end
            end
        end
    end

    assign grant     = req_valid & ~deny;
    assign req_ready = grant;
    assign any_deny  = |deny;

    // Ungranted ports keep their last addr/wdata so the memory ports see stable values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wen <= '0;
            mem_ren <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            mem_wen <= grant & req_we;
            mem_ren <= grant & ~req_we;
            for (int i = 0; i < P; i++) begin
                if (grant[i]) begin
                    addr_q[i]  <= addr_v[i];
                    wdata_q[i] <= wdata_v[i];
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Rotating on any denial bounds a held request's wait to P cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else if (any_deny) begin
            rr_ptr <= (rr_ptr == PW'(P - 1)) ? '0 : rr_ptr + 1'b1;
            if (conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    lvt_rd_delay_line #(
        .P      (P),
        .RD_LAT (RD_LAT)
    ) u_rd_delay (
        .clk   (clk),
        .reset (reset),
        .din   (mem_ren),
        .dout  (rsp_valid)
    );

    assign rsp_data = mem_rdata;

endmodule

// File: tb/tb_lvt_port_scheduler.sv
// Directed scenarios plus a randomized run against a priority-walk reference model.
module tb_lvt_port_scheduler;

    localparam int P  = 4;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int RL = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [P-1:0]    req_valid, req_we, req_ready, mem_wen, mem_ren, rsp_valid;
    logic [P*IW-1:0] req_addr, mem_addr;
    logic [P*DW-1:0] req_wdata, mem_wdata, mem_rdata, rsp_data;
    logic [1:0]      rr_ptr;
    logic [CW-1:0]   conflict_cnt;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    int           m_rr, m_cnt, cyc;
    logic [P-1:0] m_wen, m_ren;
    logic [IW-1:0] m_addr[P];
    logic [DW-1:0] m_wdata[P];
    logic [P-1:0] ren_at[int];

    lvt_port_scheduler #(
        .P(P), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .RD_LAT(RL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rr_ptr(rr_ptr), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void m_clear();
        m_rr = 0; m_cnt = 0; m_wen = '0; m_ren = '0;
        ren_at.delete();
        for (int i = 0; i < P; i++) begin m_addr[i] = '0; m_wdata[i] = '0; end
    endfunction

    function automatic logic [IW-1:0] a_of(input int i);
        return req_addr[i*IW +: IW];
    endfunction

    // Walk ports in priority order; a port is blocked by any earlier valid port it conflicts with.
    function automatic logic [P-1:0] model_ready();
        logic [P-1:0] r;
        r = '0;
        for (int k = 0; k < P; k++) begin
            int i;
            bit blocked;
            i = (m_rr + k) % P;
            blocked = 0;
            for (int h = 0; h < k; h++) begin
                int j;
                j = (m_rr + h) % P;
                if (req_valid[j] && a_of(j) == a_of(i) && (req_we[i] || req_we[j])) blocked = 1;
            end
            r[i] = req_valid[i] && !blocked;
        end
        return r;
    endfunction

    function automatic logic [P-1:0] exp_rsp();
        return ren_at.exists(cyc - RL) ? ren_at[cyc - RL] : '0;
    endfunction

    task automatic tick();
        logic [P-1:0] g;
        g = model_ready();
        @(posedge clk);
        m_wen = g & req_we;
        m_ren = g & ~req_we;
        for (int i = 0; i < P; i++) begin
            if (g[i]) begin
                m_addr[i]  = req_addr[i*IW +: IW];
                m_wdata[i] = req_wdata[i*DW +: DW];
            end
        end
        if (|(req_valid & ~g)) begin
            m_rr = (m_rr + 1) % P;
            if (m_cnt < CMAX) m_cnt++;
        end
        cyc++;
        ren_at[cyc] = m_ren;
        #1;
    endtask

    task automatic set_port(input int i, input bit v, input bit w, input int a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_we[i] = w;
        req_addr[i*IW +: IW] = IW'(a);
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        m_clear();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (mem_wen !== '0 || mem_ren !== '0) $display("FAIL reset_en got wen=%b ren=%b exp 0", mem_wen, mem_ren); else n_pass++;
        n_chk++; if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_addr got addr=%h wdata=%h exp 0", mem_addr, mem_wdata); else n_pass++;
        n_chk++; if (rsp_valid !== '0) $display("FAIL reset_rsp got=%b exp=0", rsp_valid); else n_pass++;
        n_chk++; if (rr_ptr !== '0 || conflict_cnt !== '0) $display("FAIL reset_rr_cnt got rr=%0d cnt=%0d exp 0", rr_ptr, conflict_cnt); else n_pass++;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        set_port(0, 1, 0, 8'h11, '0);
        #1;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL midrd_ready got=%b exp=0001", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        #1;
        n_chk++; if (mem_ren !== 4'b0001) $display("FAIL midrd_ren got=%b exp=0001", mem_ren); else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++; if (mem_ren !== '0 || mem_wen !== '0 || mem_addr !== '0 || mem_wdata !== '0) $display("FAIL midrd_clear got ren=%b wen=%b addr=%h exp 0", mem_ren, mem_wen, mem_addr); else n_pass++;
        n_chk++; if (rsp_valid !== '0 || rr_ptr !== '0 || conflict_cnt !== '0) $display("FAIL midrd_clear2 got rsp=%b rr=%0d cnt=%0d exp 0", rsp_valid, rr_ptr, conflict_cnt); else n_pass++;
        m_clear();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        for (int k = 0; k < RL + 2; k++) begin
            #1;
            n_chk++; if (rsp_valid !== '0) $display("FAIL midrd_no_rsp cyc%0d got=%b exp=0", k, rsp_valid); else n_pass++;
            tick();
        end
    endtask

    task automatic test_all_read();
        logic [P*DW-1:0] rd;
        do_reset();
        for (int i = 0; i < P; i++) set_port(i, 1, 0, 5, '0);
        #1;
        n_chk++; if (req_ready !== 4'b1111) $display("FAIL allrd_ready got=%b exp=1111", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        #1;
        n_chk++; if (mem_ren !== 4'b1111 || mem_wen !== 4'b0000) $display("FAIL allrd_ren got ren=%b wen=%b exp 1111/0000", mem_ren, mem_wen); else n_pass++;
        n_chk++; if (mem_addr !== {4{8'd5}}) $display("FAIL allrd_addr got=%h exp=05050505", mem_addr); else n_pass++;
        tick();
        #1;
        n_chk++; if (rsp_valid !== 4'b0000) $display("FAIL allrd_rsp_early got=%b exp=0000", rsp_valid); else n_pass++;
        tick();
        rd = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata = rd;
        #1;
        n_chk++; if (rsp_valid !== 4'b1111) $display("FAIL allrd_rsp got=%b exp=1111", rsp_valid); else n_pass++;
        n_chk++; if (rsp_data !== rd) $display("FAIL allrd_data got=%h exp=%h", rsp_data, rd); else n_pass++;
        tick();
        #1;
        n_chk++; if (rsp_valid !== 4'b0000) $display("FAIL allrd_rsp_late got=%b exp=0000", rsp_valid); else n_pass++;
    endtask

    task automatic test_write_conflict();
        do_reset();
        set_port(1, 1, 1, 7, 32'hAAAA_0001);
        set_port(2, 1, 1, 7, 32'hBBBB_0002);
        #1;
        n_chk++; if (req_ready !== 4'b0010) $display("FAIL wrc_ready1 got=%b exp=0010", req_ready); else n_pass++;
        tick();
        n_chk++; if (rr_ptr !== 2'd1 || conflict_cnt !== 4'd1) $display("FAIL wrc_rr1 got rr=%0d cnt=%0d exp 1/1", rr_ptr, conflict_cnt); else n_pass++;
        n_chk++; if (mem_wen !== 4'b0010 || mem_addr[15:8] !== 8'd7 || mem_wdata[63:32] !== 32'hAAAA_0001) $display("FAIL wrc_mem1 got wen=%b addr=%h wd=%h exp 0010/07/aaaa0001", mem_wen, mem_addr[15:8], mem_wdata[63:32]); else n_pass++;
        req_valid[1] = 1'b0;
        #1;
        n_chk++; if (req_ready !== 4'b0100) $display("FAIL wrc_ready2 got=%b exp=0100", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        n_chk++; if (mem_wen !== 4'b0100 || mem_wdata[95:64] !== 32'hBBBB_0002) $display("FAIL wrc_mem2 got wen=%b wd=%h exp 0100/bbbb0002", mem_wen, mem_wdata[95:64]); else n_pass++;
        n_chk++; if (mem_addr[15:8] !== 8'd7) $display("FAIL wrc_hold_addr got=%h exp=07", mem_addr[15:8]); else n_pass++;
        n_chk++; if (rr_ptr !== 2'd1 || conflict_cnt !== 4'd1) $display("FAIL wrc_rr2 got rr=%0d cnt=%0d exp 1/1", rr_ptr, conflict_cnt); else n_pass++;
    endtask

    task automatic test_rw_conflict();
        do_reset();
        set_port(0, 1, 1, 1, 32'h1);
        set_port(1, 1, 1, 1, 32'h2);
        repeat (3) tick();
        n_chk++; if (rr_ptr !== 2'd3 || conflict_cnt !== 4'd3) $display("FAIL rwc_setup got rr=%0d cnt=%0d exp 3/3", rr_ptr, conflict_cnt); else n_pass++;
        req_valid = '0;
        set_port(0, 1, 1, 3, 32'h33);
        set_port(3, 1, 0, 3, '0);
        #1;
        n_chk++; if (req_ready !== 4'b1000) $display("FAIL rwc_ready got=%b exp=1000", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        n_chk++; if (mem_ren !== 4'b1000 || mem_wen !== 4'b0000) $display("FAIL rwc_mem got ren=%b wen=%b exp 1000/0000", mem_ren, mem_wen); else n_pass++;
        n_chk++; if (conflict_cnt !== 4'd4 || rr_ptr !== 2'd0) $display("FAIL rwc_cnt got cnt=%0d rr=%0d exp 4/0", conflict_cnt, rr_ptr); else n_pass++;
    endtask

    task automatic test_starvation();
        bit granted;
        int waited;
        do_reset();
        granted = 0;
        waited = 0;
        set_port(1, 1, 0, 9, '0);
        for (int k = 0; k < 2 * P && !granted; k++) begin
            set_port(0, 1, 1, 9, $urandom);
            #1;
            if (req_ready[1]) begin granted = 1; waited = k + 1; end
            tick();
        end
        req_valid = '0;
        n_chk++; if (!granted || waited > P) $display("FAIL starve got granted=%0d waited=%0d exp granted within %0d", granted, waited, P); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        set_port(0, 1, 1, 0, 32'h5);
        set_port(1, 1, 1, 0, 32'h6);
        for (int k = 1; k <= (1 << CW) + 3; k++) begin
            tick();
            n_chk++; if (conflict_cnt !== CW'((k < CMAX) ? k : CMAX)) $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, conflict_cnt, (k < CMAX) ? k : CMAX); else n_pass++;
        end
        req_valid = '0;
        tick();
        n_chk++; if (conflict_cnt !== '1) $display("FAIL sat_hold got=%0d exp=%0d", conflict_cnt, CMAX); else n_pass++;
    endtask

    task automatic test_random();
        logic [P-1:0]    held, er;
        logic [P*IW-1:0] ea;
        logic [P*DW-1:0] ed, rd;
        do_reset();
        held = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < P; i++) begin
                if (!held[i]) set_port(i, ($urandom % 4) != 0, $urandom % 2, $urandom % 4, $urandom);
            end
            rd = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata = rd;
            #1;
            er = model_ready();
            for (int i = 0; i < P; i++) begin ea[i*IW +: IW] = m_addr[i]; ed[i*DW +: DW] = m_wdata[i]; end
            n_chk++; if (req_ready !== er) $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, er); else n_pass++;
            n_chk++; if (mem_wen !== m_wen || mem_ren !== m_ren) $display("FAIL rnd_en n=%0d got wen=%b ren=%b exp %b/%b", n, mem_wen, mem_ren, m_wen, m_ren); else n_pass++;
            n_chk++; if (mem_addr !== ea || mem_wdata !== ed) $display("FAIL rnd_data n=%0d got addr=%h exp=%h", n, mem_addr, ea); else n_pass++;
            n_chk++; if (rsp_valid !== exp_rsp() || rsp_data !== rd) $display("FAIL rnd_rsp n=%0d got=%b exp=%b", n, rsp_valid, exp_rsp()); else n_pass++;
            n_chk++; if (rr_ptr !== 2'(m_rr) || conflict_cnt !== CW'(m_cnt)) $display("FAIL rnd_rr_cnt n=%0d got rr=%0d cnt=%0d exp %0d/%0d", n, rr_ptr, conflict_cnt, m_rr, m_cnt); else n_pass++;
            held = req_valid & ~er;
            tick();
        end
        req_valid = '0;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        mem_rdata = '0;
        cyc = 0;
        m_clear();
        test_reset();
        test_reset_mid_read();
        test_all_read();
        test_write_conflict();
        test_rw_conflict();
        test_starvation();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
